// File: rtl/alu_pkg.sv
// Shared types, encodings and instruction field positions for the alu issue stage.
// The instruction layout is fixed for an 8-bit datapath with a 4-entry register file.
package alu_pkg;

  localparam int DATA_W  = 8;
  localparam int NREGS   = 4;
  localparam int REG_AW  = 2;
  localparam int INSTR_W = 19;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [2:0] ALU_ARITH = 3'b010;

  typedef enum logic [1:0] {IDLE, OPRD, EXEC, WB} issue_state_t;

  // {ctrl2[18:16], ctrl[15:14], imm_sel[13], wb_en[12], rd[11:10], rs1[9:8], imm/rs2[7:0]}
  localparam int CTRL2_LSB   = 16;
  localparam int CTRL_LSB    = 14;
  localparam int IMM_SEL_BIT = 13;
  localparam int WB_EN_BIT   = 12;
  localparam int RD_LSB      = 10;
  localparam int RS1_LSB     = 8;
  localparam int IMM_LSB     = 0;
  localparam int RS2_LSB     = 0;

  typedef struct packed {
    logic z;
    logic c;
    logic v;
    logic n;
  } flags_t;

  function automatic flags_t make_flags(input logic [DATA_W-1:0] y, input logic carry,
                                        input logic ovf, input logic neg);
    flags_t f;
    f.z = (y == '0);
    f.c = carry;
    f.v = ovf;
    f.n = neg;
    return f;
  endfunction

endpackage

// File: rtl/alu_issue_unit_if.sv
// Issue-stage bus: instruction handshake, alu operand/result wires, retire outputs, debug read.
// The issue unit takes the slave view; the sender/alu side takes the master view.
interface alu_issue_unit_if;
  import alu_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [INSTR_W-1:0]  in_instr;
  logic [DATA_W-1:0]   alu_a;
  logic [DATA_W-1:0]   alu_b;
  logic [1:0]          alu_ctrl;
  logic [2:0]          alu_ctrl2;
  logic [DATA_W-1:0]   alu_y;
  logic [DATA_W-1:0]   alu_cout;
  logic                alu_ovf;
  logic                alu_neg;
  logic                done;
  logic [DATA_W-1:0]   result;
  flags_t              flags;
  logic [REG_AW-1:0]   dbg_addr;
  logic [DATA_W-1:0]   dbg_data;

  modport master (
    output in_valid, in_instr, alu_y, alu_cout, alu_ovf, alu_neg, dbg_addr,
    input  in_ready, alu_a, alu_b, alu_ctrl, alu_ctrl2, done, result, flags, dbg_data
  );

  modport slave (
    input  in_valid, in_instr, alu_y, alu_cout, alu_ovf, alu_neg, dbg_addr,
    output in_ready, alu_a, alu_b, alu_ctrl, alu_ctrl2, done, result, flags, dbg_data
  );

endinterface

// File: rtl/alu_regfile.sv
// NREGS x DATA_W register file: one synchronous write port, two asynchronous operand
// read ports and an asynchronous debug read port; every entry clears on reset.
module alu_regfile
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_AW-1:0] raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [REG_AW-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic [REG_AW-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [DATA_W-1:0] regs_q [NREGS];

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          regs_q[gi] <= '0;
        end else if (we_i && (waddr_i == REG_AW'(gi))) begin
          regs_q[gi] <= wdata_i;
        end
      end
    end
  endgenerate

  assign rdata_a_o  = regs_q[raddr_a_i];
  assign rdata_b_o  = regs_q[raddr_b_i];
  assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_unit.sv
// Issue stage for the 8-bit alu: accept, read operands, let the external alu settle,
// capture result and flags, write back. One instruction in flight, 3 cycles per instruction.
module alu_issue_unit
  import alu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  alu_issue_unit_if.slave bus
);

  issue_state_t       state_q;
  logic [INSTR_W-1:0] instr_q;
  logic [DATA_W-1:0]  alu_a_q;
  logic [DATA_W-1:0]  alu_b_q;
  logic [1:0]         alu_ctrl_q;
  logic [2:0]         alu_ctrl2_q;
  logic [DATA_W-1:0]  result_q;
  flags_t             flags_q;
  logic               done_q;
  logic               in_ready_q;

  logic [REG_AW-1:0]  rs1;
  logic [REG_AW-1:0]  rs2;
  logic [REG_AW-1:0]  rd;
  logic [DATA_W-1:0]  rs1_data;
  logic [DATA_W-1:0]  rs2_data;
  logic [DATA_W-1:0]  operand_b_d;
  logic               wr_en_d;
  logic               unused_cout;

  assign rs1         = instr_q[RS1_LSB +: REG_AW];
  assign rs2         = instr_q[RS2_LSB +: REG_AW];
  assign rd          = instr_q[RD_LSB +: REG_AW];
  assign operand_b_d = instr_q[IMM_SEL_BIT] ? instr_q[IMM_LSB +: DATA_W] : rs2_data;
  // Write-back lands on the edge that leaves WB, so an OPRD right after it sees the new value.
  assign wr_en_d     = (state_q == WB) && instr_q[WB_EN_BIT];
  assign unused_cout = ^bus.alu_cout[DATA_W-1:1];

  alu_regfile u_regfile (
    .clk        (clk),
    .rst        (rst),
    .we_i       (wr_en_d),
    .waddr_i    (rd),
    .wdata_i    (result_q),
    .raddr_a_i  (rs1),
    .rdata_a_o  (rs1_data),
    .raddr_b_i  (rs2),
    .rdata_b_o  (rs2_data),
    .dbg_addr_i (bus.dbg_addr),
    .dbg_data_o (bus.dbg_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      instr_q     <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctrl_q  <= '0;
      alu_ctrl2_q <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            instr_q    <= bus.in_instr;
            in_ready_q <= 1'b0;
            state_q    <= OPRD;
          end
        end
        OPRD: begin
          alu_a_q     <= rs1_data;
          alu_b_q     <= operand_b_d;
          alu_ctrl_q  <= instr_q[CTRL_LSB +: 2];
          alu_ctrl2_q <= instr_q[CTRL2_LSB +: 3];
          state_q     <= EXEC;
        end
        EXEC: begin
          result_q   <= bus.alu_y;
          flags_q    <= make_flags(bus.alu_y, bus.alu_cout[0], bus.alu_ovf, bus.alu_neg);
          done_q     <= 1'b1;
          in_ready_q <= 1'b1;
          state_q    <= WB;
        end
        WB: begin
          if (bus.in_valid) begin
            instr_q    <= bus.in_instr;
            in_ready_q <= 1'b0;
            state_q    <= OPRD;
          end else begin
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_ctrl  = alu_ctrl_q;
  assign bus.alu_ctrl2 = alu_ctrl2_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit with a behavioural alu and a cycle-indexed reference model;
// directed cases pin literal results, then randomized instructions run against the model.
module tb_alu_issue_unit;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_issue_unit_if bus ();

  alu_issue_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Behavioural alu: add/sub when ctrl2 selects arithmetic, bitwise AND otherwise.
  logic [7:0] alu_bb;
  logic [8:0] alu_sum;
  always_comb begin
    alu_bb  = (bus.alu_ctrl == ALU_SUB) ? ~bus.alu_b : bus.alu_b;
    alu_sum = {1'b0, bus.alu_a} + {1'b0, alu_bb} + {8'd0, (bus.alu_ctrl == ALU_SUB)};
    if (bus.alu_ctrl2 == ALU_ARITH && !bus.alu_ctrl[1]) begin
      bus.alu_y    = alu_sum[7:0];
      bus.alu_cout = {bus.alu_a[7:1] ^ bus.alu_b[7:1], alu_sum[8]};
      bus.alu_ovf  = (bus.alu_a[7] == alu_bb[7]) && (alu_sum[7] != bus.alu_a[7]);
    end else begin
      bus.alu_y    = bus.alu_a & bus.alu_b;
      bus.alu_cout = {bus.alu_a[7:1] ^ bus.alu_b[7:1], 1'b0};
      bus.alu_ovf  = 1'b0;
    end
    bus.alu_neg = bus.alu_y[7];
  end

  // Reference outcome from plain integer arithmetic; flags packed {Z,C,V,N}.
  function automatic void ref_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] c,
                                 input logic [2:0] c2, output logic [7:0] y, output logic [3:0] f);
    int sa, sb, s;
    logic cy, ov;
    sa = (a > 127) ? int'(a) - 256 : int'(a);
    sb = (b > 127) ? int'(b) - 256 : int'(b);
    cy = 1'b0;
    ov = 1'b0;
    if (c2 == 3'b010 && c == 2'b00) begin
      y  = 8'((int'(a) + int'(b)) % 256);
      cy = (int'(a) + int'(b)) > 255;
      s  = sa + sb;
      ov = (s > 127) || (s < -128);
    end else if (c2 == 3'b010 && c == 2'b01) begin
      y  = 8'((int'(a) - int'(b) + 256) % 256);
      cy = (a >= b);
      s  = sa - sb;
      ov = (s > 127) || (s < -128);
    end else begin
      y = a & b;
    end
    f = {(y == 8'd0), cy, ov, y[7]};
  endfunction

  // Model state, indexed by clock interval: accept in interval acc, done in acc+3.
  logic [7:0]  m_rf [4];
  bit          m_busy = 1'b0;
  int          m_acc = 0;
  int          m_i = 0;
  logic [7:0]  m_a = 8'd0, m_b = 8'd0, m_res = 8'd0;
  logic [1:0]  m_ctrl = 2'd0;
  logic [2:0]  m_ctrl2 = 3'd0;
  logic [3:0]  m_flags = 4'd0;
  logic [18:0] p_ins = 19'd0;
  logic [7:0]  p_a = 8'd0, p_b = 8'd0, p_y = 8'd0;
  logic [3:0]  p_flags = 4'd0;

  initial begin
    bit rdy;
    for (int r = 0; r < 4; r++) m_rf[r] = 8'd0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_busy = 1'b0;
        for (int r = 0; r < 4; r++) m_rf[r] = 8'd0;
        m_a = 8'd0; m_b = 8'd0; m_ctrl = 2'd0; m_ctrl2 = 3'd0;
        m_res = 8'd0; m_flags = 4'd0;
      end else begin
        rdy = !m_busy || (m_i == m_acc + 3);
        if (m_busy && m_i == m_acc + 1) begin
          m_a = p_a; m_b = p_b; m_ctrl = p_ins[15:14]; m_ctrl2 = p_ins[18:16];
        end
        if (m_busy && m_i == m_acc + 2) begin
          m_res = p_y; m_flags = p_flags;
        end
        if (m_busy && m_i == m_acc + 3) begin
          if (p_ins[12]) m_rf[p_ins[11:10]] = p_y;
          m_busy = 1'b0;
        end
        if (rdy && bus.in_valid) begin
          p_ins = bus.in_instr;
          p_a   = m_rf[p_ins[9:8]];
          p_b   = p_ins[13] ? p_ins[7:0] : m_rf[p_ins[1:0]];
          ref_op(p_a, p_b, p_ins[15:14], p_ins[18:16], p_y, p_flags);
          m_acc  = m_i;
          m_busy = 1'b1;
        end
      end
      m_i = m_i + 1;
      chk_en = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, m_i, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("in_ready", 32'(bus.in_ready), 32'(!m_busy || (m_i == m_acc + 3)));
        check("done", 32'(bus.done), 32'(m_busy && (m_i == m_acc + 3)));
        check("result", 32'(bus.result), 32'(m_res));
        check("flags", {28'd0, bus.flags}, 32'(m_flags));
        check("alu_a", 32'(bus.alu_a), 32'(m_a));
        check("alu_b", 32'(bus.alu_b), 32'(m_b));
        check("alu_ctrl", 32'(bus.alu_ctrl), 32'(m_ctrl));
        check("alu_ctrl2", 32'(bus.alu_ctrl2), 32'(m_ctrl2));
        check("dbg_data", 32'(bus.dbg_data), 32'(m_rf[bus.dbg_addr]));
      end
    end
  end

  function automatic logic [18:0] mk(input logic [2:0] c2, input logic [1:0] c, input logic is,
                                     input logic we, input logic [1:0] rd, input logic [1:0] rs1,
                                     input logic [7:0] imm);
    return {c2, c, is, we, rd, rs1, imm};
  endfunction

  task automatic send(input logic [18:0] ins, input bit keep, output int acc);
    bit ok = 1'b0;
    acc = -1;
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    for (int k = 0; k < 30 && !ok; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = m_i;
        ok  = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout: in_ready never high, required 1");
    end
    if (!keep) bus.in_valid = 1'b0;
  endtask

  // Returns just after the write-back edge; dc is the interval in which done was seen.
  task automatic wait_done(output int dc);
    bit seen = 1'b0;
    dc = -1;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        dc = m_i;
      end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL done_timeout: done never pulsed, required 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [18:0] ins, output int acc, output int dc);
    send(ins, 1'b0, acc);
    wait_done(dc);
  endtask

  task automatic peek_reg(input logic [1:0] r, input logic [7:0] exp, input string name);
    bus.dbg_addr = r;
    #1;
    check(name, 32'(bus.dbg_data), 32'(exp));
  endtask

  initial begin
    int a, d, a2, d2;
    logic [18:0] ins;
    bit keep;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.dbg_addr = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_flags", {28'd0, bus.flags}, 32'd0);
    @(posedge clk);
    #1;

    // Add: r1=07, r2=17, r3=r1+r2
    run(mk(ALU_ARITH, ALU_ADD, 1'b1, 1'b1, 2'd1, 2'd0, 8'h07), a, d);
    run(mk(ALU_ARITH, ALU_ADD, 1'b1, 1'b1, 2'd2, 2'd0, 8'h17), a, d);
    run(mk(ALU_ARITH, ALU_ADD, 1'b0, 1'b1, 2'd3, 2'd1, 8'h02), a, d);
    check("add_latency", 32'(d - a), 32'd3);
    check("add_result", 32'(bus.result), 32'h1E);
    check("add_flags", {28'd0, bus.flags}, 32'h0);
    peek_reg(2'd3, 8'h1E, "add_dbg_r3");

    // Sub: 35-26
    run(mk(ALU_ARITH, ALU_ADD, 1'b1, 1'b1, 2'd1, 2'd0, 8'h35), a, d);
    run(mk(ALU_ARITH, ALU_ADD, 1'b1, 1'b1, 2'd2, 2'd0, 8'h26), a, d);
    run(mk(ALU_ARITH, ALU_SUB, 1'b0, 1'b1, 2'd3, 2'd1, 8'h02), a, d);
    check("sub_result", 32'(bus.result), 32'h0F);
    check("sub_z", 32'(bus.flags.z), 32'd0);
    check("sub_n", 32'(bus.flags.n), 32'd0);

    // Carry: FF+FF
    run(mk(ALU_ARITH, ALU_ADD, 1'b1, 1'b1, 2'd1, 2'd0, 8'hFF), a, d);
    run(mk(ALU_ARITH, ALU_ADD, 1'b1, 1'b1, 2'd3, 2'd1, 8'hFF), a, d);
    check("carry_result", 32'(bus.result), 32'hFE);
    check("carry_c", 32'(bus.flags.c), 32'd1);
    check("carry_n", 32'(bus.flags.n), 32'd1);

    // Zero with wb_en=0: r3 keeps FE
    run(mk(ALU_ARITH, ALU_ADD, 1'b1, 1'b1, 2'd1, 2'd0, 8'h08), a, d);
    run(mk(ALU_ARITH, ALU_SUB, 1'b1, 1'b0, 2'd3, 2'd1, 8'h08), a, d);
    check("zero_result", 32'(bus.result), 32'h00);
    check("zero_z", 32'(bus.flags.z), 32'd1);
    peek_reg(2'd3, 8'hFE, "nowb_dbg_r3");

    // Overflow: 7F+01
    run(mk(ALU_ARITH, ALU_ADD, 1'b1, 1'b1, 2'd1, 2'd0, 8'h7F), a, d);
    run(mk(ALU_ARITH, ALU_ADD, 1'b1, 1'b1, 2'd3, 2'd1, 8'h01), a, d);
    check("ovf_result", 32'(bus.result), 32'h80);
    check("ovf_v", 32'(bus.flags.v), 32'd1);
    check("ovf_n", 32'(bus.flags.n), 32'd1);

    // Negative: 00-01
    run(mk(ALU_ARITH, ALU_SUB, 1'b1, 1'b1, 2'd3, 2'd0, 8'h01), a, d);
    check("neg_result", 32'(bus.result), 32'hFF);
    check("neg_n", 32'(bus.flags.n), 32'd1);

    // Back-to-back r1=r1+1 twice from 05, in_valid held
    run(mk(ALU_ARITH, ALU_ADD, 1'b1, 1'b1, 2'd1, 2'd0, 8'h05), a, d);
    send(mk(ALU_ARITH, ALU_ADD, 1'b1, 1'b1, 2'd1, 2'd1, 8'h01), 1'b1, a);
    send(mk(ALU_ARITH, ALU_ADD, 1'b1, 1'b1, 2'd1, 2'd1, 8'h01), 1'b0, a2);
    check("b2b_spacing", 32'(a2 - a), 32'd3);
    check("b2b_first", 32'(bus.result), 32'h06);
    @(negedge clk);
    check("b2b_ready_low", 32'(bus.in_ready), 32'd0);
    wait_done(d2);
    check("b2b_done_gap", 32'(d2 - a2), 32'd3);
    check("b2b_second", 32'(bus.result), 32'h07);

    // Reset while in EXEC, then a normal instruction
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(mk(ALU_ARITH, ALU_ADD, 1'b1, 1'b1, 2'd2, 2'd0, 8'h55), 1'b0, a);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst_exec_no_done", 32'(bus.done), 32'd0);
    end
    check("rst_exec_flags", {28'd0, bus.flags}, 32'd0);
    peek_reg(2'd2, 8'h00, "rst_exec_r2");
    @(posedge clk);
    #1;
    run(mk(ALU_ARITH, ALU_ADD, 1'b1, 1'b1, 2'd2, 2'd0, 8'h33), a, d);
    check("post_rst_result", 32'(bus.result), 32'h33);
    peek_reg(2'd2, 8'h33, "post_rst_r2");

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      bus.dbg_addr = 2'($urandom_range(0, 3));
      ins = 19'($urandom);
      if ($urandom_range(0, 3) != 0) ins[18:16] = ALU_ARITH;
      keep = ($urandom_range(0, 2) == 0);
      send(ins, keep, a);
      if (n % 37 == 36) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
      end else if (!keep) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
